// File: rtl/sc_s2b_cnt.sv
// sc_s2b_cnt: stochastic-to-binary converter; counts ones per stream over a 2^len window.
// Optional macro SC_S2B_ET_EN adds the len_sel port and the early-termination shifter.
module sc_s2b_cnt #(
    parameter int unsigned TW = 8,
    parameter int unsigned N  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef SC_S2B_ET_EN
    input  logic [$clog2(TW+1)-1:0] len_sel,
`endif
    input  logic [N-1:0]            Xs,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [TW-1:0]           Zs [N],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int unsigned CW = TW + 1;
    localparam int unsigned LW = $clog2(TW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt      [N];
    logic [CW-1:0] cnt_fin  [N];
    logic [CW-1:0] shifted  [N];
    logic [TW-1:0] z_next   [N];
    logic [CW-1:0] acc;
    logic [CW-1:0] last_acc;
    logic          accept;
    logic [LW-1:0] len_q;

`ifdef SC_S2B_ET_EN
    logic [LW-1:0] len_clamp;

    assign len_clamp = (len_sel > LW'(TW)) ? LW'(TW) : len_sel;
`else
    assign len_q = LW'(TW);
`endif

    // Index of the final sample in the window (L-1)
    assign last_acc = CW'((CW'(1) << len_q) - CW'(1));
    assign accept   = (state == RUN) && in_valid;

    // Final count includes the sample accepted on the closing edge
    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            cnt_fin[j] = cnt[j] + CW'(Xs[j]);
`ifdef SC_S2B_ET_EN
            shifted[j] = cnt_fin[j] << (LW'(TW) - len_q);
`else
            shifted[j] = cnt_fin[j];
`endif
            z_next[j]  = shifted[j][TW] ? {TW{1'b1}} : shifted[j][TW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
`ifdef SC_S2B_ET_EN
            len_q     <= LW'(TW);
`endif
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned j = 0; j < N; j++) begin
                cnt[j] <= '0;
                Zs[j]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        acc      <= '0;
`ifdef SC_S2B_ET_EN
                        len_q    <= len_clamp;
`endif
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        for (int unsigned j = 0; j < N; j++) begin
                            cnt[j] <= '0;
                        end
                    end
                end

                RUN: begin
                    if (accept) begin
                        acc <= acc + CW'(1);
                        for (int unsigned j = 0; j < N; j++) begin
                            cnt[j] <= cnt_fin[j];
                        end
                        if (acc == last_acc) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            for (int unsigned j = 0; j < N; j++) begin
                                Zs[j] <= z_next[j];
                            end
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            // Chain straight into the next window without an idle cycle
                            state    <= RUN;
                            acc      <= '0;
`ifdef SC_S2B_ET_EN
                            len_q    <= len_clamp;
`endif
                            in_ready <= 1'b1;
                            for (int unsigned j = 0; j < N; j++) begin
                                cnt[j] <= '0;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_s2b_cnt.sv
// tb_sc_s2b_cnt: scoreboard bench for sc_s2b_cnt at TW=4, N=2; works with or without SC_S2B_ET_EN.
module tb_sc_s2b_cnt;

    localparam int unsigned TW = 4;
    localparam int unsigned N  = 2;
    localparam int unsigned LW = $clog2(TW + 1);
`ifdef SC_S2B_ET_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    typedef struct {
        logic [TW-1:0] z0;
        logic [TW-1:0] z1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
`ifdef SC_S2B_ET_EN
    logic [LW-1:0] len_sel;
`endif
    logic [N-1:0]  Xs;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] Zs [N];
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   c0, c1;
    exp_t sb [$];

    sc_s2b_cnt #(.TW(TW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SC_S2B_ET_EN
        .len_sel   (len_sel),
`endif
        .Xs        (Xs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Zs        (Zs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int eff_len(input int len);
        return ET ? ((len > int'(TW)) ? int'(TW) : len) : int'(TW);
    endfunction

    function automatic logic [TW-1:0] norm(input int c, input int len);
        int v;
        v = c << (int'(TW) - eff_len(len));
        return (v > (1 << TW) - 1) ? {TW{1'b1}} : TW'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input int len, output int s);
        s = cyc;
`ifdef SC_S2B_ET_EN
        len_sel = LW'(len);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = 0;
        c1 = 0;
    endtask

    task automatic feed(input logic [N-1:0] x, input logic v);
        Xs       = x;
        in_valid = v;
        tick();
        if (v) begin
            c0 += int'(x[0]);
            c1 += int'(x[1]);
        end
    endtask

    task automatic push(input int len);
        exp_t e;
        e.z0 = norm(c0, len);
        e.z1 = norm(c1, len);
        sb.push_back(e);
    endtask

    // Scoreboard consumer: wait for out_valid, check latency and compare against the queue head
    task automatic collect(input string name, input int s, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=0 after %0d extra cycles, required 1", name, n);
            return;
        end
        checks++;
        if (cyc - s != lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc - s, lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb_empty: result with no expected entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (Zs[0] !== e.z0) begin
            errors++;
            $display("FAIL %s_z0: got %0d expected %0d", name, Zs[0], e.z0);
        end
        checks++;
        if (Zs[1] !== e.z1) begin
            errors++;
            $display("FAIL %s_z1: got %0d expected %0d", name, Zs[1], e.z1);
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b busy=%b, expected 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; Xs = '0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef SC_S2B_ET_EN
        len_sel = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (Zs[0] !== '0) begin errors++; $display("FAIL reset_z0: got %0d expected 0", Zs[0]); end
        checks++; if (Zs[1] !== '0) begin errors++; $display("FAIL reset_z1: got %0d expected 0", Zs[1]); end
    endtask

    task automatic test_full_window();
        int s, l;
        l = 1 << eff_len(4);
        start_window(4, s);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL full_run_entry: in_ready=%b busy=%b expected 1 1", in_ready, busy);
        end
        for (int i = 0; i < l; i++) feed({(i % 2 == 0), 1'b1}, 1'b1);
        in_valid = 1'b0;
        push(4);
        collect("full", s, l + 1);
        release_result("full");
    endtask

    task automatic test_early_term();
        int s, l;
        l = 1 << eff_len(2);
        start_window(2, s);
        for (int i = 0; i < l; i++) feed({1'b0, (i % 4 != 2)}, 1'b1);
        in_valid = 1'b0;
        push(2);
        collect("early", s, l + 1);
        release_result("early");
    endtask

    task automatic test_bubbles();
        int s, l, acc, n;
        logic [6:0] vp;
        vp  = 7'b1011001;
        l   = 1 << eff_len(2);
        acc = 0;
        n   = 0;
        start_window(2, s);
        while (acc < l) begin
            feed(2'b11, vp[n % 7]);
            if (vp[n % 7]) acc++;
            n++;
        end
        in_valid = 1'b0;
        push(2);
        collect("bubbles", s, n + 1);
        release_result("bubbles");
    endtask

    task automatic test_len_one();
        int s, l;
        l = 1 << eff_len(0);
        start_window(0, s);
        for (int i = 0; i < l; i++) feed(2'b01, 1'b1);
        in_valid = 1'b0;
        push(0);
        collect("len_one", s, l + 1);
        release_result("len_one");
    endtask

    task automatic test_clamp();
        int s, l;
        l = 1 << eff_len(7);
        start_window(7, s);
        for (int i = 0; i < l; i++) feed({(i >= 10), (i < 9)}, 1'b1);
        in_valid = 1'b0;
        push(7);
        collect("clamp", s, l + 1);
        release_result("clamp");
    endtask

    task automatic test_back_to_back();
        int            s, l;
        logic [TW-1:0] z0e, z1e;
        l = 1 << eff_len(3);
        start_window(3, s);
        for (int i = 0; i < l; i++) begin
            start = (i == 2);
            feed(N'($urandom), 1'b1);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        z0e = norm(c0, 3);
        z1e = norm(c1, 3);
        push(3);
        collect("b2b_first", s, l + 1);
        for (int k = 0; k < 5; k++) begin
            Xs       = N'($urandom);
            in_valid = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid: got %b expected 1", out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
            checks++; if (Zs[0] !== z0e) begin errors++; $display("FAIL hold_z0: got %0d expected %0d", Zs[0], z0e); end
            checks++; if (Zs[1] !== z1e) begin errors++; $display("FAIL hold_z1: got %0d expected %0d", Zs[1], z1e); end
        end
        // Accept the result and start the next window in the same cycle
        in_valid = 1'b0;
        s = cyc;
`ifdef SC_S2B_ET_EN
        len_sel = LW'(1);
`endif
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        c0 = 0;
        c1 = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL chain_entry: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        l = 1 << eff_len(1);
        for (int i = 0; i < l; i++) feed(N'($urandom), 1'b1);
        in_valid = 1'b0;
        push(1);
        collect("b2b_second", s, l + 1);
        release_result("b2b_second");
    endtask

    task automatic test_reset_mid_run();
        int s, l;
        start_window(4, s);
        for (int i = 0; i < 7; i++) feed(2'b11, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (Zs[0] !== '0 || Zs[1] !== '0) begin
            errors++; $display("FAIL midrst_zs: got %0d %0d expected 0 0", Zs[0], Zs[1]);
        end
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        l = 1 << eff_len(4);
        start_window(4, s);
        for (int i = 0; i < l; i++) feed({1'b0, (i < 5)}, 1'b1);
        in_valid = 1'b0;
        push(4);
        collect("after_rst", s, l + 1);
        release_result("after_rst");
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_early_term();
        test_bubbles();
        test_len_one();
        test_clamp();
        test_back_to_back();
        test_reset_mid_run();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
